fu_scheduler: RTL
=================

Name: fu_scheduler

Overview:
Sequencer/arbiter that shares one functional_unit (ALU + MADD datapath) between two requesters. Round-robin arbitration; the granted operation's operands are registered and held stable on the FU inputs for a per-class latency. The FU result is captured into a result register and returned with the requester ID over a valid/ready handshake. Sits between the issue logic and the functional_unit instance.

Parameters:
WIDTH, 32, operand/result width (matches FU A/B/C/Z).
ALU_LAT, 1, cycles from accept to result capture for INST[4]=0; legal 1..15.
MADD_LAT, 2, cycles from accept to result capture for INST[4]=1; legal 1..15.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous, active-high reset.
REQ_VALID  input  2  per-requester op valid; bit i = requester i.
REQ_READY  output  2  per-requester accept.
REQ_A, REQ_B, REQ_C  input  2*WIDTH each  operands; slice [i*WIDTH +: WIDTH] = requester i.
REQ_INST  input  2*5  opcode per requester; bit 4 selects MADD.
REQ_CI  input  2  carry-in per requester.
FU_A, FU_B, FU_C  output  WIDTH each  registered operands to the FU.
FU_INST  output  5  registered opcode to the FU.
FU_CI  output  1  registered carry-in to the FU.
FU_Z  input  WIDTH  FU result (combinational from FU_*).
FU_FLAGS  input  4  FU flags.
RES_VALID  output  1  result valid.
RES_READY  input  1  consumer accept.
RES_Z  output  WIDTH  captured result.
RES_FLAGS  output  4  captured flags.
RES_ID  output  1  requester that issued the result.

Behaviour:
- Reset (async, RST=1): state=IDLE, RR pointer=1 (requester 0 wins first), counter=0; all FU_*, RES_* and RES_VALID=0; REQ_READY=0 while RST=1.
- States: IDLE, EXEC, HOLD.
- IDLE: grant = single requester valid, or, if both valid, the one not last served. REQ_READY[i]=grant[i] (combinational from state, REQ_VALID, pointer); at most one bit set; 0 when no valid.
- Accept (IDLE and REQ_VALID[i] and REQ_READY[i]) at edge k: latch requester i's A/B/C/INST/CI into FU_*; RES_ID<=i; pointer<=i; counter<=(INST[4] ? MADD_LAT : ALU_LAT)-1; ->EXEC.
- EXEC: REQ_READY=0. If counter==0: RES_Z<=FU_Z; RES_FLAGS<=INST[4] ? 4'b0 : FU_FLAGS; RES_VALID<=1; ->HOLD. Otherwise counter decrements.
- Latency: RES_VALID rises at edge k+LAT. FU_* remain constant from edge k until the next accept.
- HOLD: RES_VALID, RES_Z, RES_FLAGS and RES_ID stay stable until RES_READY=1. On handshake edge: RES_VALID<=0, ->IDLE. No accept happens in the same cycle, so throughput is one op per LAT+2 cycles at best.
- Backpressure: RES_READY held low keeps HOLD indefinitely; requesters are stalled with REQ_READY=0.
- Requesters must hold VALID and operands until accepted. A VALID that drops before accept is simply not granted, with no error.
- Both valid in consecutive ops: strict alternation 0,1,0,1...
- RST asserted mid-EXEC/HOLD: the operation is aborted immediately, no RES_VALID is produced, and the pointer returns to 1.
- Counter is 4 bits. Latencies outside 1..15 are illegal and are caught by an elaboration-time check.

Decomposition:
- Package fu_sched_pkg: state enum (IDLE/EXEC/HOLD), INST_MADD_BIT=4, LAT_MAX=15, counter width constant.
- One sub-module: rr_arbiter2, which performs the 2-way round-robin grant from REQ_VALID and the last-served pointer, with pointer update on accept.

Test Plan:
- Reset then single op: REQ_VALID=01, INST=ALU add, A=5, B=7 -> REQ_READY=01 same cycle; RES_VALID one cycle after accept, RES_Z=FU model value (12), RES_ID=0.
- MADD latency: REQ_VALID=10, INST[4]=1, A=3, B=4, C=5 -> RES_VALID exactly 2 cycles after accept, RES_Z=17, RES_FLAGS=0, RES_ID=1; FU_* stable throughout.
- Contention: REQ_VALID=11 held for 4 ops, RES_READY=1 -> grant order 0,1,0,1; RES_ID sequence 0,1,0,1.
- Backpressure: RES_READY=0 for 10 cycles after RES_VALID -> RES_* unchanged, REQ_READY=00; RES_READY=1 -> IDLE next cycle, new accept the cycle after.
- Async reset in EXEC (MADD_LAT=4, RST at cycle 2) -> outputs 0 immediately without a clock edge; no RES_VALID; the next op from requester 0 with both valid is granted first.

Source files
------------

// File: rtl/fu_sched_pkg.sv
// Shared definitions for the functional-unit scheduler.
//   state_t        : sequencer states (IDLE accept, EXEC wait on FU, HOLD result)
//   INST_MADD_BIT  : opcode bit that selects the MADD latency class
//   LAT_MAX        : largest latency the down-counter can express
//   CNT_W / INST_W : latency counter width, opcode width
package fu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int INST_MADD_BIT = 4;
  localparam int LAT_MAX       = 15;
  localparam int CNT_W         = 4;
  localparam int INST_W        = 5;

endpackage

// File: rtl/fu_scheduler_rr.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   en       : arbitration allowed this cycle (scheduler idle, not in reset)
//   valid    : per-requester request
//   grant    : one-hot grant (or zero); a non-zero grant is an accept
// The pointer holds the last-served requester; reset value 1 lets
// requester 0 win the first contended cycle.
module rr_arbiter2
  import fu_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (grant != 2'b00) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/fu_scheduler.sv
// Shares one functional unit between two requesters.
//   CLK, RST                  : clock, asynchronous active-high reset
//   REQ_VALID/REQ_READY       : per-requester issue handshake
//   REQ_A/B/C/INST/CI         : packed per-requester operands, slice i = requester i
//   FU_A/B/C/INST/CI          : registered operands, held until the next accept
//   FU_Z, FU_FLAGS            : combinational FU result
//   RES_VALID/RES_READY       : result handshake
//   RES_Z, RES_FLAGS, RES_ID  : captured result, flags and issuing requester
module fu_scheduler
  import fu_sched_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ALU_LAT  = 1,
  parameter int MADD_LAT = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            REQ_VALID,
  output logic [1:0]            REQ_READY,
  input  logic [2*WIDTH-1:0]    REQ_A,
  input  logic [2*WIDTH-1:0]    REQ_B,
  input  logic [2*WIDTH-1:0]    REQ_C,
  input  logic [2*INST_W-1:0]   REQ_INST,
  input  logic [1:0]            REQ_CI,
  output logic [WIDTH-1:0]      FU_A,
  output logic [WIDTH-1:0]      FU_B,
  output logic [WIDTH-1:0]      FU_C,
  output logic [INST_W-1:0]     FU_INST,
  output logic                  FU_CI,
  input  logic [WIDTH-1:0]      FU_Z,
  input  logic [3:0]            FU_FLAGS,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [WIDTH-1:0]      RES_Z,
  output logic [3:0]            RES_FLAGS,
  output logic                  RES_ID
);

  if (ALU_LAT < 1 || ALU_LAT > LAT_MAX) begin : g_bad_alu_lat
    $error("fu_scheduler: ALU_LAT must be within 1..15");
  end
  if (MADD_LAT < 1 || MADD_LAT > LAT_MAX) begin : g_bad_madd_lat
    $error("fu_scheduler: MADD_LAT must be within 1..15");
  end

  // Counter preload is latency-1: EXEC captures when the counter reads 0.
  localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] MADD_CNT = CNT_W'(MADD_LAT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         grant;
  logic               sel;
  logic [WIDTH-1:0]   a_sel, b_sel, c_sel;
  logic [INST_W-1:0]  inst_sel;
  logic               ci_sel;
  logic [CNT_W-1:0]   cnt_load;

  // Arbitration is gated by RST so REQ_READY is low throughout reset.
  rr_arbiter2 u_arb (
    .clk   (CLK),
    .rst   (RST),
    .en    ((state_q == IDLE) && !RST),
    .valid (REQ_VALID),
    .grant (grant)
  );

  assign REQ_READY = grant;
  assign sel       = grant[1];
  assign a_sel     = sel ? REQ_A[2*WIDTH-1:WIDTH] : REQ_A[WIDTH-1:0];
  assign b_sel     = sel ? REQ_B[2*WIDTH-1:WIDTH] : REQ_B[WIDTH-1:0];
  assign c_sel     = sel ? REQ_C[2*WIDTH-1:WIDTH] : REQ_C[WIDTH-1:0];
  assign inst_sel  = sel ? REQ_INST[2*INST_W-1:INST_W] : REQ_INST[INST_W-1:0];
  assign ci_sel    = sel ? REQ_CI[1] : REQ_CI[0];
  assign cnt_load  = inst_sel[INST_MADD_BIT] ? MADD_CNT : ALU_CNT;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant != 2'b00) state_d = EXEC;
      EXEC:    if (cnt_q == '0)    state_d = HOLD;
      HOLD:    if (RES_READY)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      FU_A      <= '0;
      FU_B      <= '0;
      FU_C      <= '0;
      FU_INST   <= '0;
      FU_CI     <= 1'b0;
      RES_VALID <= 1'b0;
      RES_Z     <= '0;
      RES_FLAGS <= '0;
      RES_ID    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant != 2'b00) begin
            FU_A    <= a_sel;
            FU_B    <= b_sel;
            FU_C    <= c_sel;
            FU_INST <= inst_sel;
            FU_CI   <= ci_sel;
            RES_ID  <= sel;
            cnt_q   <= cnt_load;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            RES_Z     <= FU_Z;
            // MADD does not produce meaningful flags; report them as zero.
            RES_FLAGS <= FU_INST[INST_MADD_BIT] ? 4'b0000 : FU_FLAGS;
            RES_VALID <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (RES_READY) RES_VALID <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
